mem_access_unit: RTL

Parametrised successor to the MEM-stage data memory. It is a byte-addressed, little-endian data RAM with configurable depth and configurable access wait states, and it uses a valid/ready request handshake so the pipeline can stall. It adds unsigned loads, alignment checking and a registered response. It sits between EX/MEM and MEM/WB and passes ALU results through for non-memory ops.

---
 rtl/mem_pkg.sv | 59 +++++
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_byte_ram.sv | 29 ++
 rtl/mem_access_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: MemOp encodings, FSM state type, captured-request struct,
// op classification and alignment helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LW  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LHU = 4'd3,
    MEM_LB  = 4'd4,
    MEM_LBU = 4'd5,
    MEM_SW  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SB  = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Request fields frozen at acceptance.
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] result;
    logic [31:0] data;
    logic        reg_write;
    logic [4:0]  dst;
  } req_t;

  function automatic logic op_is_load(input logic [3:0] op);
    case (op)
      MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    case (op)
      MEM_SW, MEM_SH, MEM_SB: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Byte ops, NOPs and illegal encodings are always aligned.
  function automatic logic op_aligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      MEM_LW, MEM_SW:          return (lo == 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: return (lo[0] == 1'b0);
      default:                 return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between EX/MEM and MEM/WB around the data memory.
// Latency: n/a (wiring only).
// Backpressure: req_valid_i/req_ready_o on the request side; the response is an unthrottled pulse.
// Ports: request (valid, ready, op, address/ALU result, store data, writeback enable/dst),
// response (valid pulse, writeback data/enable/dst, misalign flag).
interface mem_access_unit_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  MemOp_i;
  logic [31:0] result_i;
  logic [31:0] MemData_i;
  logic        RegWrite_i;
  logic [4:0]  WriteRegDst_i;

  logic        resp_valid_o;
  logic [31:0] WriteRegData_o;
  logic        RegWrite_o;
  logic [4:0]  WriteRegDst_o;
  logic        misalign_o;

  // Pipeline side: drives requests, consumes responses.
  modport master (
    output req_valid_i, MemOp_i, result_i, MemData_i, RegWrite_i, WriteRegDst_i,
    input  req_ready_o, resp_valid_o, WriteRegData_o, RegWrite_o, WriteRegDst_o, misalign_o
  );

  // Memory unit side.
  modport slave (
    input  req_valid_i, MemOp_i, result_i, MemData_i, RegWrite_i, WriteRegDst_i,
    output req_ready_o, resp_valid_o, WriteRegData_o, RegWrite_o, WriteRegDst_o, misalign_o
  );

endinterface

// File: rtl/mem_byte_ram.sv
// Data RAM built from four byte lanes sharing one word index.
// Latency: combinational word read; write takes effect at the rising edge.
// Backpressure: none, one access per cycle.
// Ports: clk, word_idx (word address), wr_en (per-lane write enable),
// wr_data (lane-positioned write data), rd_data (word at word_idx). Contents not reset.
module mem_byte_ram #(
  parameter int DEPTH_BYTES = 4096,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] word_idx,
  input  logic [3:0]       wr_en,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data
);

  localparam int WORDS = DEPTH_BYTES / 4;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [WORDS];

    always_ff @(posedge clk) begin
      if (wr_en[l]) mem[word_idx] <= wr_data[8*l +: 8];
    end

    assign rd_data[8*l +: 8] = mem[word_idx];
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory: byte-addressed little-endian RAM with loads/stores, alignment check, ALU passthrough.
// Latency: NOP 1 cycle; load/store WAIT_STATES+1 cycles from acceptance to the resp_valid_o pulse.
// Backpressure: req_ready_o low while an access waits out its busy cycles; responses cannot be stalled.
// Ports: clk, rst (async active-high), bus (slave side of mem_access_unit_if).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = $clog2(DEPTH_BYTES),
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);

  localparam int IDX_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] wdata_q, wdata_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  dst_q, dst_d;
  logic        misalign_q, misalign_d;

  req_t              req_in;
  req_t              cur;
  logic              accept;
  logic              complete;
  logic [ADDR_W-1:0] addr;
  logic              is_ld;
  logic              is_st;
  logic              aligned;
  logic [3:0]        lane_mask;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic [IDX_W-1:0]  word_idx;

  always_comb begin
    req_in.op        = bus.MemOp_i;
    req_in.result    = bus.result_i;
    req_in.data      = bus.MemData_i;
    req_in.reg_write = bus.RegWrite_i;
    req_in.dst       = bus.WriteRegDst_i;

    // With no wait states an access completes on its accept edge, so it works
    // straight off the inputs; otherwise it works off the captured copy.
    cur     = (state_q == ST_IDLE) ? req_in : req_q;
    accept  = bus.req_valid_i && (state_q == ST_IDLE);
    addr    = cur.result[ADDR_W-1:0];
    is_ld   = op_is_load(cur.op);
    is_st   = op_is_store(cur.op);
    aligned = op_aligned(cur.op, addr[1:0]);

    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    resp_valid_d = 1'b0;
    wdata_d      = wdata_q;
    reg_write_d  = reg_write_q;
    dst_d        = dst_q;
    misalign_d   = misalign_q;
    complete     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = req_in;
          if ((is_ld || is_st) && (WAIT_STATES != 0)) begin
            state_d = ST_BUSY;
            cnt_d   = 3'(WAIT_STATES);
          end else begin
            complete = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Lane steering: data is replicated across lanes, enables pick the lanes.
    lane_mask = 4'b0000;
    ram_wdata = cur.data;
    case (cur.op)
      MEM_SW: lane_mask = 4'b1111;
      MEM_SH: begin
        lane_mask = addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{cur.data[15:0]}};
      end
      MEM_SB: begin
        lane_mask = 4'b0001 << addr[1:0];
        ram_wdata = {4{cur.data[7:0]}};
      end
      default: lane_mask = 4'b0000;
    endcase
    ram_we = (complete && is_st && aligned) ? lane_mask : 4'b0000;

    // Bring the addressed byte/half down to bit 0 before extension.
    shifted = ram_rdata >> {addr[1:0], 3'b000};
    case (cur.op)
      MEM_LW:  load_val = ram_rdata;
      MEM_LH:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LHU: load_val = {16'h0000, shifted[15:0]};
      MEM_LB:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LBU: load_val = {24'h000000, shifted[7:0]};
      default: load_val = ZeroWord;
    endcase

    if (complete) begin
      resp_valid_d = 1'b1;
      dst_d        = cur.dst;
      misalign_d   = 1'b0;
      if (!aligned) begin
        wdata_d     = ZeroWord;
        reg_write_d = 1'b0;
        misalign_d  = 1'b1;
      end else if (is_ld) begin
        wdata_d     = load_val;
        reg_write_d = cur.reg_write;
      end else if (is_st) begin
        wdata_d     = ZeroWord;
        reg_write_d = cur.reg_write;
      end else begin
        wdata_d     = cur.result;
        reg_write_d = cur.reg_write;
      end
    end
  end

  if (ADDR_W > 2) begin : g_idx
    assign word_idx = addr[ADDR_W-1:2];
  end else begin : g_idx_one
    assign word_idx = '0;
  end

  mem_byte_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk      (clk),
    .word_idx (word_idx),
    .wr_en    (ram_we),
    .wr_data  (ram_wdata),
    .rd_data  (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      req_q        <= '0;
      resp_valid_q <= 1'b0;
      wdata_q      <= ZeroWord;
      reg_write_q  <= 1'b0;
      dst_q        <= 5'd0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      resp_valid_q <= resp_valid_d;
      wdata_q      <= wdata_d;
      reg_write_q  <= reg_write_d;
      dst_q        <= dst_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.req_ready_o    = (state_q == ST_IDLE);
  assign bus.resp_valid_o   = resp_valid_q;
  assign bus.WriteRegData_o = wdata_q;
  assign bus.RegWrite_o     = reg_write_q;
  assign bus.WriteRegDst_o  = dst_q;
  assign bus.misalign_o     = misalign_q;

endmodule
